deserializer_buf: RTL and testbench

Parametrised serial-to-parallel converter with a show-ahead output FIFO. It accepts one bit per clock under a write/busy handshake and assembles WIDTH-bit words in a selectable bit order. It buffers up to DEPTH completed words for a downstream consumer that acknowledges each word. It sits between the serial bit source and the word consumer, and replaces the single-word deserializer wherever back-to-back words must be absorbed without stalling the sender.

---
 rtl/deser_pkg.sv | 13 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/deserializer_buf.sv | 86 ++++++++
 tb/tb_deserializer_buf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants and types for the buffered serial-to-parallel converter.
package deser_pkg;

  localparam int DESER_WIDTH = 8;
  localparam int DESER_DEPTH = 2;

  // Which end of the assembled word the first received bit ends up in.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead circular-buffer FIFO; DEPTH need not be a power of two.
module sync_fifo #(
  parameter int WIDTH = deser_pkg::DESER_WIDTH,
  parameter int DEPTH = deser_pkg::DESER_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Guard push/pop against full/empty so the buffer state can never corrupt.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Status and head are decoded from registered state only.
  always_comb begin
    full  = (count == LW'(DEPTH));
    empty = (count == '0);
    level = count;
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/deserializer_buf.sv
// Serial-to-parallel converter feeding a show-ahead word FIFO with busy/ack handshake.
module deserializer_buf #(
  parameter int WIDTH     = deser_pkg::DESER_WIDTH,
  parameter int DEPTH     = deser_pkg::DESER_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear_in,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overrun
);

  import deser_pkg::*;

  localparam bit_order_t ORDER = MSB_FIRST ? deser_pkg::MSB_FIRST : LSB_FIRST;
  localparam int         CW    = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             accept;
  logic             word_done;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Handshake decode; the FIFO is fed the word including the bit being accepted.
  always_comb begin
    accept    = write_in && !fifo_full && !clear_in;
    word_done = accept && (bit_cnt == CW'(WIDTH - 1));
    pop       = ack_in && !fifo_empty && !clear_in;
    if (ORDER == deser_pkg::MSB_FIRST) shreg_nxt = {shreg[WIDTH-2:0], data_in};
    else                               shreg_nxt = {data_in, shreg[WIDTH-1:1]};
  end

  // Assembly register and bit counter; refused bits leave the partial word intact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear_in) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= shreg_nxt;
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  // Sticky overrun: set by any write attempt while busy, cleared only by flush or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      overrun <= 1'b0;
    else if (clear_in)              overrun <= 1'b0;
    else if (write_in && fifo_full) overrun <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear_in),
    .push  (word_done),
    .pop   (pop),
    .din   (shreg_nxt),
    .head  (data_out),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Busy and ready are the FIFO's registered full/empty decodes.
  always_comb begin
    status_out = fifo_full;
    data_ready = !fifo_empty;
  end

endmodule

// File: tb/tb_deserializer_buf.sv
// Bench for deserializer_buf: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_deserializer_buf;

  typedef logic [7:0] word_t;

  logic       clock = 1'b0;
  logic       reset, clear_in, data_in, write_in, ack_in;
  word_t      dout_m, dout_l;
  logic       rdy_m, rdy_l, st_m, st_l, ovr_m, ovr_l;
  logic [1:0] lvl_m, lvl_l;

  int checks = 0;
  int errors = 0;

  // Reference model: expected-word queues plus shared count / overrun state.
  word_t q_m[$];
  word_t q_l[$];
  word_t asm_m, asm_l;
  int    cnt;
  bit    ovr;

  always #5 clock = ~clock;

  deserializer_buf #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .clear_in(clear_in), .data_in(data_in),
    .write_in(write_in), .ack_in(ack_in), .data_out(dout_m), .data_ready(rdy_m),
    .status_out(st_m), .level(lvl_m), .overrun(ovr_m)
  );

  deserializer_buf #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .clear_in(clear_in), .data_in(data_in),
    .write_in(write_in), .ack_in(ack_in), .data_out(dout_l), .data_ready(rdy_l),
    .status_out(st_l), .level(lvl_l), .overrun(ovr_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    q_l.delete();
    cnt = 0;
    ovr = 1'b0;
  endtask

  // One clock edge of the reference behaviour; busy is the pre-edge occupancy.
  task automatic model_step(input bit wr, input bit b, input bit ack, input bit clr);
    bit busy;
    if (clr) begin
      model_reset();
    end else begin
      busy = (q_m.size() == 2);
      if (wr && busy) ovr = 1'b1;
      if (ack && q_m.size() > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (wr && !busy) begin
        asm_m[7 - cnt] = b;
        asm_l[cnt]     = b;
        if (cnt == 7) begin
          q_m.push_back(asm_m);
          q_l.push_back(asm_l);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ready_msb", rdy_m, q_m.size() != 0);
    chk("ready_lsb", rdy_l, q_l.size() != 0);
    chk("level_msb", lvl_m, q_m.size());
    chk("level_lsb", lvl_l, q_l.size());
    chk("busy_msb",  st_m,  q_m.size() == 2);
    chk("busy_lsb",  st_l,  q_l.size() == 2);
    chk("ovr_msb",   ovr_m, ovr);
    chk("ovr_lsb",   ovr_l, ovr);
    if (q_m.size() > 0) chk("head_msb", dout_m, q_m[0]);
    if (q_l.size() > 0) chk("head_lsb", dout_l, q_l[0]);
  endtask

  task automatic cycle(input bit wr, input bit b, input bit ack, input bit clr);
    write_in = wr;
    data_in  = b;
    ack_in   = ack;
    clear_in = clr;
    @(posedge clock);
    model_step(wr, b, ack, clr);
    #1;
    check_all();
    write_in = 1'b0;
    data_in  = 1'b0;
    ack_in   = 1'b0;
    clear_in = 1'b0;
  endtask

  // Sends the first n bits of v, most significant bit first in time.
  task automatic send_bits(input word_t v, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, v[7 - i], 1'b0, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dout_m"}, dout_m, 0);
    chk({tag, "_dout_l"}, dout_l, 0);
    chk({tag, "_rdy"},    {rdy_m, rdy_l}, 0);
    chk({tag, "_busy"},   {st_m, st_l}, 0);
    chk({tag, "_lvl"},    {lvl_m, lvl_l}, 0);
    chk({tag, "_ovr"},    {ovr_m, ovr_l}, 0);
  endtask

  initial begin
    reset = 1'b1; clear_in = 1'b0; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
    model_reset();
    asm_m = '0;
    asm_l = '0;
    #12;
    chk_zero_outputs("reset");
    reset = 1'b0;

    // Test 1: A5, MSB first; same stream lands as A5 LSB first (palindrome).
    send_bits(8'hA5, 8);
    chk("t1_dout_m", dout_m, 8'hA5);
    chk("t1_dout_l", dout_l, 8'hA5);
    chk("t1_rdy",    rdy_m, 1);
    chk("t1_lvl",    lvl_m, 1);

    // Test 2: pop, then 1 followed by seven zeros.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(8'h80, 8);
    chk("t2_dout_m", dout_m, 8'h80);
    chk("t2_dout_l", dout_l, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);  // ack while empty is ignored

    // Test 3: fill, refused writes, overrun, one ack frees a slot.
    send_bits(8'h31, 8);
    send_bits(8'hC5, 8);
    chk("t3_lvl",  lvl_m, 2);
    chk("t3_busy", st_m, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_ovr", ovr_m, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_busy_after_ack", st_m, 0);
    chk("t3_head_m", dout_m, 8'hC5);
    chk("t3_head_l", dout_l, 8'hA3);
    send_bits(8'h31, 8);  // refused bits must not have leaked into this word
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Test 4: push of word 2 coincides with pop of word 1.
    send_bits(8'h6B, 8);
    send_bits(8'h96, 7);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_lvl",    lvl_m, 1);
    chk("t4_dout_m", dout_m, 8'h96);
    chk("t4_dout_l", dout_l, 8'h69);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Test 5: asynchronous reset after 5 bits, then a fresh word.
    send_bits(8'hFF, 5);
    #2 reset = 1'b1;
    #1;
    chk_zero_outputs("t5_async");
    model_reset();
    @(posedge clock);
    #3 reset = 1'b0;
    send_bits(8'h6B, 8);
    chk("t5_dout_m", dout_m, 8'h6B);
    chk("t5_dout_l", dout_l, 8'hD6);
    chk("t5_lvl",    lvl_m, 1);

    // Test 6: flush when full with overrun, then flush a 3-bit partial (write with clear is dropped).
    send_bits(8'h31, 8);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_ovr", ovr_m, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_lvl", lvl_m, 0);
    chk("t6_rdy", rdy_m, 0);
    chk("t6_ovr", ovr_m, 0);
    send_bits(8'hE0, 3);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(8'h4E, 8);
    chk("t6_dout_m", dout_m, 8'h4E);
    chk("t6_dout_l", dout_l, 8'h72);
    chk("t6_lvl2",   lvl_m, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
